// File: rtl/ysyx_23060184_mem_access.sv
// Memory-stage access controller: drives one AXI4-Lite load or store per
// EX/MEM instruction and aligns load data. Optional bus-error reporting under MEM_ACCESS_FAULT_EN.
module ysyx_23060184_mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        Evalid,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic        Wready,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  RopcodeM,
  input  logic [3:0]  WmaskM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        Mready,
  output logic        Mvalid,
  output logic [31:0] ReadDataM,
  output logic        AccessFaultM,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  dbg_state
);

  localparam int DATA_WIDTH     = 32;
  localparam int WMASK_LENGTH   = 4;
  localparam int ROPCODE_LENGTH = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t                  state;
  logic                    aw_done;
  logic                    w_done;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic                    fault_q;
  logic                    fault_set;
  logic [DATA_WIDTH-1:0]   aligned_addr;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [2*WMASK_LENGTH-1:0] strb_wide;
  logic                    in_wr_req;
  logic                    unused_m;

  // Load lane extraction: byte lane from addr[1:0], half lane from addr[1].
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [ROPCODE_LENGTH-1:0] rop,
    input logic [1:0]                lane,
    input logic [DATA_WIDTH-1:0]     word
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (rop)
      3'd1:    res = {{16{h[15]}}, h};
      3'd2:    res = {16'h0000, h};
      3'd3:    res = {{24{b[7]}}, b};
      3'd4:    res = {24'h000000, b};
      default: res = word;
    endcase
    return res;
  endfunction

  assign aligned_addr = {ALUResultM[31:2], 2'b00};
  assign store_data   = WriteDataM << {ALUResultM[1:0], 3'b000};
  assign strb_wide    = {4'b0000, WmaskM} << ALUResultM[1:0];
  assign in_wr_req    = (state == S_WR_REQ) && !reset;

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; the valid side holds its payload until then.
  assign Mready    = (state == S_IDLE) && !reset;
  assign Mvalid    = (state == S_HOLD) && !reset;
  assign ReadDataM = read_data_q;
  assign dbg_state = state;

  assign arvalid = (state == S_RD_ADDR) && !reset;
  assign araddr  = arvalid ? aligned_addr : '0;
  assign rready  = (state == S_RD_DATA) && !reset;
  assign awvalid = in_wr_req && !aw_done;
  assign awaddr  = awvalid ? aligned_addr : '0;
  assign wvalid  = in_wr_req && !w_done;
  assign wdata   = wvalid ? store_data : '0;
  assign wstrb   = wvalid ? strb_wide[WMASK_LENGTH-1:0] : '0;
  assign bready  = (state == S_WR_RESP) && !reset;

  // The M-side op flags are implied by the path the FSM took.
  assign unused_m = ^{MemReadM, MemWriteM};

`ifdef MEM_ACCESS_FAULT_EN
  assign fault_set = ((state == S_RD_DATA) && rvalid && (rresp != 2'b00)) ||
                     ((state == S_WR_RESP) && bvalid && (bresp != 2'b00));
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign fault_set   = 1'b0;
`endif

  assign AccessFaultM = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Evalid) begin
            read_data_q <= '0;
            fault_q     <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (MemReadE)       state <= S_RD_ADDR;
            else if (MemWriteE) state <= S_WR_REQ;
            else                state <= S_HOLD;
          end
        end
        S_RD_ADDR: begin
          if (arready) state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (rvalid) begin
            read_data_q <= fault_set ? '0 : load_extract(RopcodeM, ALUResultM[1:0], rdata);
            fault_q     <= fault_set;
            state       <= S_HOLD;
          end
        end
        S_WR_REQ: begin
          // Address and data channels retire independently, possibly together.
          aw_done <= aw_done | awready;
          w_done  <= w_done | wready;
          if ((aw_done | awready) && (w_done | wready)) state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (bvalid) begin
            fault_q <= fault_set;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (Wready) begin
            fault_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_mem_access.sv
// Directed bench for ysyx_23060184_mem_access with a reactive AXI4-Lite slave
// driven from tasks; expectations are hand-computed per vector.
module tb_ysyx_23060184_mem_access;

  logic        clk;
  logic        reset;
  logic        Evalid, MemReadE, MemWriteE, Wready, MemReadM, MemWriteM;
  logic [2:0]  RopcodeM;
  logic [3:0]  WmaskM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        Mready, Mvalid, AccessFaultM;
  logic [31:0] ReadDataM;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ysyx_23060184_mem_access dut (
    .clk(clk), .reset(reset), .Evalid(Evalid), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .Wready(Wready), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .RopcodeM(RopcodeM),
    .WmaskM(WmaskM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Mready(Mready),
    .Mvalid(Mvalid), .ReadDataM(ReadDataM), .AccessFaultM(AccessFaultM), .araddr(araddr),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one load and act as the read slave; lat counts cycles after acceptance until Mvalid.
  task automatic run_load(input logic [2:0] rop, input logic [31:0] addr, input logic [31:0] data,
                          input int ar_wait, input int r_wait, input logic [1:0] resp,
                          output int lat, output logic [31:0] rd, output logic flt,
                          output logic [31:0] ar_seen);
    int ar_cnt;
    int r_cnt;
    ar_cnt = 0; r_cnt = 0; lat = -1; rd = 32'hx; flt = 1'bx; ar_seen = 32'hx;
    RopcodeM = rop; ALUResultM = addr; MemReadM = 1'b1; MemWriteM = 1'b0;
    WmaskM = 4'hf; WriteDataM = 32'h0;
    Evalid = 1'b1; MemReadE = 1'b1; MemWriteE = 1'b0;
    step();
    Evalid = 1'b0; MemReadE = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Mvalid) begin
        lat = c; rd = ReadDataM; flt = AccessFaultM;
        break;
      end
      if (arvalid) ar_seen = araddr;
      arready = arvalid && (ar_cnt >= ar_wait);
      if (arvalid) ar_cnt++;
      rvalid = rready && (r_cnt >= r_wait);
      if (rready) r_cnt++;
      rdata = rvalid ? data : 32'h0;
      rresp = rvalid ? resp : 2'b00;
      step();
    end
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
  endtask

  // Driver: issue one store and act as the write slave; per-channel valid cycles are recorded.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                           input int aw_wait, input int w_wait, input int b_wait, input logic [1:0] resp,
                           output int lat, output int aw_cyc, output int w_cyc, output int b_cyc,
                           output logic [31:0] aw_seen, output logic [31:0] wd_seen,
                           output logic [3:0] ws_seen, output logic [31:0] rd, output logic flt);
    int b_cnt;
    b_cnt = 0; lat = -1; aw_cyc = 0; w_cyc = 0; b_cyc = -1;
    aw_seen = 32'hx; wd_seen = 32'hx; ws_seen = 4'hx; rd = 32'hx; flt = 1'bx;
    RopcodeM = 3'd0; ALUResultM = addr; MemReadM = 1'b0; MemWriteM = 1'b1;
    WmaskM = mask; WriteDataM = data;
    Evalid = 1'b1; MemReadE = 1'b0; MemWriteE = 1'b1;
    step();
    Evalid = 1'b0; MemWriteE = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (Mvalid) begin
        lat = c; rd = ReadDataM; flt = AccessFaultM;
        break;
      end
      awready = awvalid && (aw_cyc >= aw_wait);
      wready  = wvalid && (w_cyc >= w_wait);
      if (awvalid) begin aw_cyc++; aw_seen = awaddr; end
      if (wvalid) begin w_cyc++; wd_seen = wdata; ws_seen = wstrb; end
      bvalid = bready && (b_cnt >= b_wait);
      if (bready) b_cnt++;
      if (bvalid) b_cyc = c;
      bresp = bvalid ? resp : 2'b00;
      step();
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (Mready !== 1'b0) begin errors++; $display("FAIL reset_mready got %0h want 0", Mready); end
    checks++; if (Mvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %0h want 0", Mvalid); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", ReadDataM); end
    checks++; if (AccessFaultM !== 1'b0) begin errors++; $display("FAIL reset_fault got %0h want 0", AccessFaultM); end
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin errors++;
      $display("FAIL reset_axi_ctrl got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); end
    checks++; if ({araddr, awaddr, wdata, wstrb} !== 100'h0) begin errors++;
      $display("FAIL reset_axi_payload got %h %h %h %h want 0", araddr, awaddr, wdata, wstrb); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    reset = 1'b0;
    #1;
    checks++; if (Mready !== 1'b1) begin errors++; $display("FAIL reset_release_mready got %0h want 1", Mready); end
  endtask

  task automatic test_lb();
    int lat; logic [31:0] rd; logic flt; logic [31:0] ar;
    run_load(3'd3, 32'h8000_0003, 32'h80FF_FFFF, 0, 0, 2'b00, lat, rd, flt, ar);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got %0d want 3", lat); end
    checks++; if (ar !== 32'h8000_0000) begin errors++; $display("FAIL lb_araddr got %h want 80000000", ar); end
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", rd); end
    checks++; if (Mready !== 1'b0) begin errors++; $display("FAIL lb_hold_mready got %0h want 0", Mready); end
    step();
    checks++; if (Mvalid !== 1'b0 || dbg_state !== 3'd0) begin errors++;
      $display("FAIL lb_release got mvalid %0h state %0d want 0 0", Mvalid, dbg_state); end
    checks++; if (ReadDataM !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_retain got %h want ffffff80", ReadDataM); end
  endtask

  task automatic test_lhu();
    int lat; logic [31:0] rd; logic flt; logic [31:0] ar;
    run_load(3'd2, 32'h8000_0002, 32'hBEEF_1234, 1, 2, 2'b00, lat, rd, flt, ar);
    checks++; if (lat !== 6) begin errors++; $display("FAIL lhu_latency got %0d want 6", lat); end
    checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", rd); end
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  rop_t  [6] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd1};
    logic [31:0] addr_t [6] = '{32'h100, 32'h102, 32'h101, 32'h102, 32'h103, 32'h100};
    logic [31:0] data_t [6] = '{32'hDEADBEEF, 32'h80017FFF, 32'h1234F600, 32'h00420000, 32'hCAFEF00D, 32'h00007FFF};
    logic [31:0] exp_t  [6] = '{32'hDEADBEEF, 32'hFFFF8001, 32'h000000F6, 32'h00000042, 32'hCAFEF00D, 32'h00007FFF};
    int lat; logic [31:0] rd; logic flt; logic [31:0] ar;
    for (int i = 0; i < 6; i++) begin
      run_load(rop_t[i], addr_t[i], data_t[i], 0, 0, 2'b00, lat, rd, flt, ar);
      checks++; if (rd !== exp_t[i]) begin errors++; $display("FAIL load_vec%0d got %h want %h", i, rd, exp_t[i]); end
      checks++; if (ar !== {addr_t[i][31:2], 2'b00}) begin errors++;
        $display("FAIL load_vec%0d_araddr got %h want %h", i, ar, {addr_t[i][31:2], 2'b00}); end
      step();
    end
  endtask

  task automatic test_sb();
    int lat, awc, wc, bc; logic [31:0] aw, wd, rd; logic [3:0] ws; logic flt;
    run_store(32'h8000_0001, 32'h0000_00AB, 4'b0001, 2, 0, 1, 2'b00, lat, awc, wc, bc, aw, wd, ws, rd, flt);
    checks++; if (awc !== 3) begin errors++; $display("FAIL sb_awvalid_cycles got %0d want 3", awc); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sb_wvalid_cycles got %0d want 1", wc); end
    checks++; if (ws !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b want 0010", ws); end
    checks++; if (wd !== 32'h0000_AB00) begin errors++; $display("FAIL sb_wdata got %h want 0000ab00", wd); end
    checks++; if (aw !== 32'h8000_0000) begin errors++; $display("FAIL sb_awaddr got %h want 80000000", aw); end
    checks++; if (lat !== 6 || lat !== bc + 1) begin errors++; $display("FAIL sb_latency got %0d bvalid %0d want 6 5", lat, bc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_readdata got %h want 0", rd); end
    step();
  endtask

  task automatic test_stores();
    int lat, awc, wc, bc; logic [31:0] aw, wd, rd; logic [3:0] ws; logic flt;
    run_store(32'h0000_0200, 32'h1122_3344, 4'b1111, 0, 0, 0, 2'b00, lat, awc, wc, bc, aw, wd, ws, rd, flt);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d want 3", lat); end
    checks++; if (ws !== 4'b1111 || wd !== 32'h1122_3344) begin errors++;
      $display("FAIL sw_payload got %b %h want 1111 11223344", ws, wd); end
    checks++; if (awc !== 1 || wc !== 1) begin errors++; $display("FAIL sw_valid_cycles got %0d %0d want 1 1", awc, wc); end
    step();
    run_store(32'h0000_0202, 32'h0000_BEEF, 4'b0011, 0, 2, 0, 2'b00, lat, awc, wc, bc, aw, wd, ws, rd, flt);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sh_latency got %0d want 5", lat); end
    checks++; if (ws !== 4'b1100 || wd !== 32'hBEEF_0000) begin errors++;
      $display("FAIL sh_payload got %b %h want 1100 beef0000", ws, wd); end
    checks++; if (awc !== 1 || wc !== 3) begin errors++; $display("FAIL sh_valid_cycles got %0d %0d want 1 3", awc, wc); end
    checks++; if (aw !== 32'h0000_0200) begin errors++; $display("FAIL sh_awaddr got %h want 00000200", aw); end
    step();
  endtask

  task automatic test_nonmem();
    Wready = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    Evalid = 1'b1; MemReadE = 1'b0; MemWriteE = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (Mvalid !== 1'b1 || Mready !== 1'b0) begin errors++;
        $display("FAIL nonmem_stall%0d got mvalid %0h mready %0h want 1 0", i, Mvalid, Mready); end
      if (i < 3) step();
    end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL nonmem_readdata got %h want 0", ReadDataM); end
    Wready = 1'b1;
    step();
    Evalid = 1'b0;
    checks++; if (dbg_state !== 3'd0 || Mready !== 1'b1 || Mvalid !== 1'b0) begin errors++;
      $display("FAIL nonmem_release got state %0d mready %0h mvalid %0h want 0 1 0", dbg_state, Mready, Mvalid); end
  endtask

  task automatic test_back_to_back();
    int lat, awc, wc, bc; logic [31:0] aw, wd, rd, ar; logic [3:0] ws; logic flt;
    run_load(3'd4, 32'h0000_0301, 32'h0000_5A00, 0, 0, 2'b00, lat, rd, flt, ar);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL b2b_load got %h want 0000005a", rd); end
    step();
    run_store(32'h0000_0304, 32'h0000_0077, 4'b0001, 0, 0, 0, 2'b00, lat, awc, wc, bc, aw, wd, ws, rd, flt);
    checks++; if (rd !== 32'h0 || lat !== 3) begin errors++; $display("FAIL b2b_store got %h lat %0d want 0 3", rd, lat); end
    step();
  endtask

  task automatic test_reset_mid();
    RopcodeM = 3'd0; ALUResultM = 32'h0000_0040; MemReadM = 1'b1; MemWriteM = 1'b0;
    Evalid = 1'b1; MemReadE = 1'b1;
    step();
    Evalid = 1'b0; MemReadE = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL midrst_rd_data got rready %0h want 1", rready); end
    reset = 1'b1;
    step();
    checks++; if (dbg_state !== 3'd0 || rready !== 1'b0) begin errors++;
      $display("FAIL midrst_state got state %0d rready %0h want 0 0", dbg_state, rready); end
    checks++; if (Mvalid !== 1'b0 || Mready !== 1'b0) begin errors++;
      $display("FAIL midrst_hs got mvalid %0h mready %0h want 0 0", Mvalid, Mready); end
    step();
    checks++; if (Mready !== 1'b0) begin errors++; $display("FAIL midrst_hold_mready got %0h want 0", Mready); end
    reset = 1'b0;
    #1;
    checks++; if (Mready !== 1'b1) begin errors++; $display("FAIL midrst_release got %0h want 1", Mready); end
  endtask

  task automatic test_fault();
    int lat, awc, wc, bc; logic [31:0] aw, wd, rd, ar; logic [3:0] ws; logic flt;
    logic        exp_flt;
    logic [31:0] exp_rd;
`ifdef MEM_ACCESS_FAULT_EN
    exp_flt = 1'b1; exp_rd = 32'h0;
`else
    exp_flt = 1'b0; exp_rd = 32'h1234_5678;
`endif
    run_load(3'd0, 32'h8000_0010, 32'h1234_5678, 0, 0, 2'b10, lat, rd, flt, ar);
    checks++; if (flt !== exp_flt) begin errors++; $display("FAIL fault_load_flag got %0h want %0h", flt, exp_flt); end
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL fault_load_data got %h want %h", rd, exp_rd); end
    step();
    checks++; if (AccessFaultM !== 1'b0) begin errors++; $display("FAIL fault_clear got %0h want 0", AccessFaultM); end
    run_store(32'h8000_0020, 32'h0000_0001, 4'b1111, 0, 0, 0, 2'b11, lat, awc, wc, bc, aw, wd, ws, rd, flt);
    checks++; if (flt !== exp_flt) begin errors++; $display("FAIL fault_store_flag got %0h want %0h", flt, exp_flt); end
    step();
    run_load(3'd0, 32'h8000_0010, 32'h0000_0009, 0, 0, 2'b00, lat, rd, flt, ar);
    checks++; if (flt !== 1'b0 || rd !== 32'h9) begin errors++; $display("FAIL fault_okay got %0h %h want 0 9", flt, rd); end
    step();
  endtask

  initial begin
    reset = 1'b1; Evalid = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0; Wready = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; RopcodeM = 3'd0; WmaskM = 4'h0;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    test_reset();
    test_lb();
    test_lhu();
    test_loads();
    test_sb();
    test_stores();
    test_nonmem();
    test_back_to_back();
    test_reset_mid();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
